control_sequencer: RTL and testbench
====================================

# control_sequencer

Parametrised successor of the team's fixed 2-bit start/count/done control FSM. On a start request it counts from 0 up to a run-time programmable limit, optionally slowed by a fixed prescaler, then raises a one-cycle done pulse. It adds one-shot and continuous modes, abort, and busy/abort status outputs. It sits between the front-end start logic and the datapath loader in the 150 kHz clock domain.

## Interface

- WIDTH, 2, width of the count and the limit
- PRESCALE, 1, clock cycles per count step (≥1; 1 = step every cycle)

- clock150kHz  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- inicio  input  1  start request, sampled only in CHECK (and in LOAD when continuo=1)
- abortar  input  1  abort request, sampled in COUNT and LOAD
- continuo  input  1  mode: 0 = one-shot, 1 = auto-restart after each LOAD
- limite  input  WIDTH  terminal count, latched at each run start
- dout  output  WIDTH  current count value
- ocupado  output  1  high while in COUNT or LOAD
- listo  output  1  one-cycle done pulse, high in LOAD
- abortado  output  1  registered one-cycle pulse after an accepted abort

## Operation

- States: CHECK (idle), COUNT, LOAD. Reset → CHECK.
- Registers: state, cnt (WIDTH), lim_reg (WIDTH), pre (ceil(log2(PRESCALE)) bits, ≥1), abortado.
- CHECK: cnt=0, pre=0. If inicio=1, then lim_reg←limite, cnt←0, pre←0, → COUNT. Otherwise stay.
- COUNT: tick = (pre==PRESCALE-1). Without a tick, pre←pre+1. On a tick, pre←0; if cnt==lim_reg → LOAD, else cnt←cnt+1.
- LOAD: lasts exactly one cycle, with listo=1. Next cnt←0, pre←0.
  - If continuo=1 and abortar=0: lim_reg←limite, → COUNT. inicio is not required.
  - Otherwise → CHECK.
- Abort: abortar=1 in COUNT → CHECK, cnt←0, pre←0, abortado=1 the next cycle. abortar=1 in LOAD: listo still asserts (the run completed), → CHECK, abortado stays 0.
- inicio in COUNT or LOAD is ignored. A limite change mid-run has no effect until the next latch.
- Width rules:
  - cnt never exceeds lim_reg and never wraps, because the compare happens before the increment.
  - limite = 2^WIDTH-1 is legal.
  - limite = 0 gives one tick in COUNT and then LOAD.
- Outputs:
  - dout = cnt.
  - ocupado and listo are decoded from the state register.
  - abortado is a flop.
- Reset asserted mid-run → CHECK immediately, with all outputs 0. No listo and no abortado are generated.

## Timing

- Reset values: dout=0, ocupado=0, listo=0, abortado=0. Internally state=CHECK, lim_reg=0, pre=0.
- inicio sampled high at edge k in CHECK:
  - cycle k+1: COUNT, dout=0, ocupado=1.
  - dout holds each value for PRESCALE cycles: 0,1,…,L.
  - LOAD (listo=1) at cycle k+1+(L+1)·PRESCALE.
  - CHECK at the following cycle.
- Start-to-listo latency is (L+1)·PRESCALE+1 edges. Example: WIDTH=2, PRESCALE=1, L=3 gives 5.
- Continuous mode: listo period is (L+1)·PRESCALE+1 cycles. dout returns to 0 in the cycle after LOAD, and ocupado stays high.
- Abort sampled at edge j in COUNT: cycle j+1 is CHECK with dout=0, ocupado=0, abortado=1. abortado falls at j+2.
- inicio and abortar are synchronous to clock150kHz. No internal synchroniser.

## Test plan

- Defaults (WIDTH=2, PRESCALE=1), limite=3, one inicio pulse → dout 0,1,2,3, then listo high for 1 cycle, 5 edges after inicio. ocupado high for 5 cycles, then idle.
- WIDTH=4, PRESCALE=3, limite=5 → each dout value held 3 cycles. listo at edge 19 after inicio. limite changed to 2 mid-run has no effect.
- continuo=1, limite=2, PRESCALE=1 → listo every 4 cycles with ocupado continuously high. Change limite to 0 and the next run (after that LOAD) gives listo every 2 cycles.
- Abort during COUNT at cnt=2 → next cycle dout=0, ocupado=0, abortado=1 for exactly 1 cycle, no listo. Abort coincident with LOAD in continuous mode → listo=1, then CHECK, abortado=0.
- limite=0 and limite=2^WIDTH-1 (WIDTH=3, limite=7) → listo after 2 and 9 edges respectively. dout never exceeds limite and never wraps.
- Async reset asserted mid-COUNT between clock edges → outputs 0 immediately. After release, inicio=0 keeps the block in CHECK. A held inicio restarts the run from cnt=0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: start/count/done controller with a programmable terminal
// count, a fixed prescaler, one-shot or continuous runs, and abort.
//
// state | meaning
// CHECK | idle, waiting for inicio
// COUNT | stepping cnt from 0 up to lim_reg, one step every PRESCALE cycles
// LOAD  | single done cycle (listo=1), then restart or return to idle
module control_sequencer #(
    parameter int WIDTH    = 2,
    parameter int PRESCALE = 1
) (
    input  logic             clock150kHz,
    input  logic             reset,
    input  logic             inicio,
    input  logic             abortar,
    input  logic             continuo,
    input  logic [WIDTH-1:0] limite,
    output logic [WIDTH-1:0] dout,
    output logic             ocupado,
    output logic             listo,
    output logic             abortado
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        CHECK = 2'd0,
        COUNT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] lim_reg, lim_next;
    logic [PW-1:0]    pre, pre_next;
    logic             abort_next;
    logic             tick;

    assign tick = (pre == PRE_LAST);

    // State and datapath registers; reset forces idle with all outputs low.
    always_ff @(posedge clock150kHz or posedge reset) begin
        if (reset) begin
            state    <= CHECK;
            cnt      <= '0;
            lim_reg  <= '0;
            pre      <= '0;
            abortado <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            lim_reg  <= lim_next;
            pre      <= pre_next;
            abortado <= abort_next;
        end
    end

    // Next-state and next-datapath logic. The terminal compare comes before
    // the increment, so cnt tops out at lim_reg and can never wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lim_next   = lim_reg;
        pre_next   = pre;
        abort_next = 1'b0;
        case (state)
            CHECK: begin
                cnt_next = '0;
                pre_next = '0;
                if (inicio) begin
                    lim_next   = limite;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (abortar) begin
                    cnt_next   = '0;
                    pre_next   = '0;
                    abort_next = 1'b1;
                    state_next = CHECK;
                end else if (!tick) begin
                    pre_next = pre + PW'(1);
                end else begin
                    pre_next = '0;
                    if (cnt == lim_reg) begin
                        state_next = LOAD;
                    end else begin
                        cnt_next = cnt + WIDTH'(1);
                    end
                end
            end
            LOAD: begin
                cnt_next = '0;
                pre_next = '0;
                // An abort here still lets the completed run report listo,
                // but suppresses the automatic restart and abortado.
                if (continuo && !abortar) begin
                    lim_next   = limite;
                    state_next = COUNT;
                end else begin
                    state_next = CHECK;
                end
            end
            default: begin
                cnt_next   = '0;
                pre_next   = '0;
                state_next = CHECK;
            end
        endcase
    end

    // Outputs decoded straight from the registers.
    always_comb begin
        dout    = cnt;
        ocupado = (state == COUNT) || (state == LOAD);
        listo   = (state == LOAD);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a cycle table for the default
// configuration plus hand-written prescaler, full-range and reset sequences.
module tb_control_sequencer;

    logic clk;
    logic reset;

    // Instance 0: WIDTH=2, PRESCALE=1
    logic       ini0, abt0, cont0;
    logic [1:0] lim0, dout0;
    logic       oc0, li0, ab0;

    // Instance 1: WIDTH=4, PRESCALE=3
    logic       ini1;
    logic [3:0] lim1, dout1;
    logic       oc1, li1, ab1;

    // Instance 2: WIDTH=3, PRESCALE=1
    logic       ini2;
    logic [2:0] lim2, dout2;
    logic       oc2, li2, ab2;

    logic       zero;

    int errors = 0;
    int checks = 0;

    control_sequencer #(.WIDTH(2), .PRESCALE(1)) dut0 (
        .clock150kHz(clk), .reset(reset), .inicio(ini0), .abortar(abt0),
        .continuo(cont0), .limite(lim0), .dout(dout0), .ocupado(oc0),
        .listo(li0), .abortado(ab0)
    );

    control_sequencer #(.WIDTH(4), .PRESCALE(3)) dut1 (
        .clock150kHz(clk), .reset(reset), .inicio(ini1), .abortar(zero),
        .continuo(zero), .limite(lim1), .dout(dout1), .ocupado(oc1),
        .listo(li1), .abortado(ab1)
    );

    control_sequencer #(.WIDTH(3), .PRESCALE(1)) dut2 (
        .clock150kHz(clk), .reset(reset), .inicio(ini2), .abortar(zero),
        .continuo(zero), .limite(lim2), .dout(dout2), .ocupado(oc2),
        .listo(li2), .abortado(ab2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ini;
        logic       abt;
        logic       cont;
        logic [1:0] lim;
        logic [1:0] e_dout;
        logic       e_oc;
        logic       e_li;
        logic       e_ab;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ini, input logic abt, input logic cont,
                       input logic [1:0] lim, input logic [1:0] d,
                       input logic oc, input logic li, input logic ab);
        vec_t v;
        v.ini = ini; v.abt = abt; v.cont = cont; v.lim = lim;
        v.e_dout = d; v.e_oc = oc; v.e_li = li; v.e_ab = ab;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int maxd;
        int prev;
        logic wrapped;

        zero = 1'b0;
        ini0 = 0; abt0 = 0; cont0 = 0; lim0 = '0;
        ini1 = 0; lim1 = '0;
        ini2 = 0; lim2 = '0;
        reset = 1'b1;
        #12;
        check("reset_dout", dout0, 0);
        check("reset_ocupado", oc0, 0);
        check("reset_listo", li0, 0);
        check("reset_abortado", ab0, 0);
        reset = 1'b0;
        #2;

        // one-shot, limite=3; inicio and a limite change mid-run are ignored
        add(0,0,0,0, 0,0,0,0);
        add(1,0,0,3, 0,1,0,0);
        add(0,0,0,3, 1,1,0,0);
        add(1,0,0,0, 2,1,0,0);
        add(0,0,0,0, 3,1,0,0);
        add(0,0,0,0, 3,1,1,0);
        add(0,0,0,0, 0,0,0,0);
        // continuous, limite=2 then 0 after the second LOAD
        add(1,0,1,2, 0,1,0,0);
        add(0,0,1,2, 1,1,0,0);
        add(0,0,1,2, 2,1,0,0);
        add(0,0,1,2, 2,1,1,0);
        add(0,0,1,2, 0,1,0,0);
        add(0,0,1,0, 1,1,0,0);
        add(0,0,1,0, 2,1,0,0);
        add(0,0,1,0, 2,1,1,0);
        add(0,0,1,0, 0,1,0,0);
        add(0,0,1,0, 0,1,1,0);
        add(0,0,1,0, 0,1,0,0);
        add(0,0,1,0, 0,1,1,0);
        add(0,0,0,0, 0,0,0,0);
        // abort in COUNT at cnt=2, then abort in CHECK has no effect
        add(1,0,0,3, 0,1,0,0);
        add(0,0,0,3, 1,1,0,0);
        add(0,0,0,3, 2,1,0,0);
        add(0,1,0,3, 0,0,0,1);
        add(0,0,0,3, 0,0,0,0);
        add(0,1,0,3, 0,0,0,0);
        // abort coincident with LOAD in continuous mode
        add(1,0,1,1, 0,1,0,0);
        add(0,0,1,1, 1,1,0,0);
        add(0,0,1,1, 1,1,1,0);
        add(0,1,1,1, 0,0,0,0);
        add(0,0,0,1, 0,0,0,0);
        // limite=0: one count cycle then LOAD
        add(1,0,0,0, 0,1,0,0);
        add(0,0,0,0, 0,1,1,0);
        add(0,0,0,0, 0,0,0,0);

        foreach (tbl[i]) begin
            ini0 = tbl[i].ini; abt0 = tbl[i].abt;
            cont0 = tbl[i].cont; lim0 = tbl[i].lim;
            edge_sample();
            check($sformatf("row%0d_dout", i), dout0, tbl[i].e_dout);
            check($sformatf("row%0d_ocupado", i), oc0, tbl[i].e_oc);
            check($sformatf("row%0d_listo", i), li0, tbl[i].e_li);
            check($sformatf("row%0d_abortado", i), ab0, tbl[i].e_ab);
        end
        ini0 = 0; abt0 = 0; cont0 = 0;

        // PRESCALE=3, limite=5: each value held 3 cycles, listo at edge 19
        ini1 = 1; lim1 = 4'd5;
        edge_sample();
        ini1 = 0;
        for (int i = 1; i <= 18; i++) begin
            check($sformatf("pre_dout_e%0d", i), dout1, (i - 1) / 3);
            check($sformatf("pre_ocupado_e%0d", i), oc1, 1);
            check($sformatf("pre_listo_e%0d", i), li1, 0);
            if (i == 7) lim1 = 4'd2;
            edge_sample();
        end
        check("pre_listo_e19", li1, 1);
        check("pre_dout_e19", dout1, 5);
        edge_sample();
        check("pre_idle_ocupado", oc1, 0);
        check("pre_idle_listo", li1, 0);
        check("pre_idle_abortado", ab1, 0);

        // WIDTH=3, limite=7: listo 9 edges after start, no wrap
        ini2 = 1; lim2 = 3'd7;
        edge_sample();
        ini2 = 0;
        n = 1; maxd = dout2; prev = dout2; wrapped = 1'b0;
        while (!li2 && n < 30) begin
            edge_sample();
            n++;
            if (dout2 > maxd) maxd = dout2;
            if (dout2 != prev && dout2 != prev + 1) wrapped = 1'b1;
            prev = dout2;
        end
        check("full_latency", n, 9);
        check("full_max_dout", maxd, 7);
        check("full_no_wrap", wrapped, 0);
        edge_sample();
        check("full_idle_ocupado", oc2, 0);

        // async reset mid-COUNT, then idle, then held inicio restarts
        ini0 = 1; lim0 = 2'd3;
        edge_sample();
        ini0 = 0;
        edge_sample();
        check("rst_pre_dout", dout0, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_dout", dout0, 0);
        check("rst_async_ocupado", oc0, 0);
        check("rst_async_listo", li0, 0);
        check("rst_async_abortado", ab0, 0);
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            check($sformatf("rst_idle_ocupado%0d", i), oc0, 0);
            check($sformatf("rst_idle_abortado%0d", i), ab0, 0);
        end
        ini0 = 1;
        edge_sample();
        check("rst_restart_dout", dout0, 0);
        check("rst_restart_ocupado", oc0, 1);
        edge_sample();
        check("rst_held_dout", dout0, 1);
        ini0 = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
